serial_adder: RTL and testbench

Parametrised, bit-serial add/subtract unit: the next-generation replacement for the single-bit combinational half adder. It accepts two WIDTH-bit operands over a valid/ready handshake and resolves them LSB-first through one full-adder slice with a registered carry, one bit per clock. It then presents sum, carry-out and signed overflow on a held output handshake. The unit sits between operand registers and result consumers in small Tiny Tapeout datapaths where area matters more than throughput.

---
 rtl/serial_adder_if.sv | 27 ++
 rtl/serial_adder.sv | 102 ++++++++++
 tb/tb_serial_adder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The producer/consumer side uses master; the adder itself uses slave.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder slice with a registered carry, LSB first,
// one bit per clock, with the result held on a valid/ready output handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    serial_adder_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic x, y, s, c_next;

    assign x      = a_sh_q[0];
    assign y      = b_sh_q[0];
    assign s      = x ^ y ^ carry_q;
    assign c_next = (x & y) | (carry_q & (x ^ y));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_sh_d            = a_sh_q >> 1;
                b_sh_d            = b_sh_q >> 1;
                sum_d             = sum_q >> 1;
                sum_d[WIDTH-1]    = s;
                carry_d           = c_next;
                cnt_d             = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    // carry_q here is the carry into the MSB slice
                    cout_d  = c_next;
                    ovf_d   = carry_q ^ c_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed add/sub vectors plus a WIDTH=1 build
// exercised as a half adder.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus ();
    serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    serial_adder_if #(.WIDTH(1)) bus1 ();
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per consumed result.
    res_t mon_e;
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %0h, expected no result", bus.sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum", {24'd0, bus.sum}, {24'd0, mon_e.sum});
                check("cout", {31'd0, bus.cout}, {31'd0, mon_e.cout});
                check("ovf", {31'd0, bus.ovf}, {31'd0, mon_e.ovf});
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input bit push,
                        input logic [7:0] es, input logic ec, input logic eo);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0, expected 1");
            return;
        end
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        if (push) exp_q.push_back(res_t'({es, ec, eo}));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Counts edges from accept to out_valid.
    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.out_valid && n < 40);
        check("latency", n, 8);
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] es, input logic ec, input logic eo);
        send(a, b, s, 1'b1, es, ec, eo);
        wait_done();
        @(posedge clk);
        #1;
        check("in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        check("busy_after", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int n;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.sub        = 1'b0;
        bus.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.sub       = 1'b0;
        bus1.out_ready = 1'b1;

        #12;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_sum", {24'd0, bus.sum}, 32'd0);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        op(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

        // Backpressure with live junk on the inputs
        bus.out_ready = 1'b0;
        send(8'h33, 8'h44, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        wait_done();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            bus.sub      = i[0];
            @(negedge clk);
            check("bp_sum", {24'd0, bus.sum}, 32'h77);
            check("bp_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        op(8'hC8, 8'h9C, 1'b0, 8'h64, 1'b1, 1'b1);

        // Reset mid-RUN discards the operation
        send(8'hAA, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        check("mrst_sum", {24'd0, bus.sum}, 32'd0);
        check("mrst_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

        // WIDTH=1: half-adder truth table, one-edge RUN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus1.in_valid = 1'b1;
            bus1.a        = k[1];
            bus1.b        = k[0];
            @(posedge clk);
            #1 bus1.in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("w1_out_valid", {31'd0, bus1.out_valid}, 32'd1);
            check("w1_sum", {31'd0, bus1.sum}, {31'd0, k[1] ^ k[0]});
            check("w1_cout", {31'd0, bus1.cout}, {31'd0, k[1] & k[0]});
            @(posedge clk);
            #1;
            check("w1_in_ready", {31'd0, bus1.in_ready}, 32'd1);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
